// File: rtl/nes_clk_enable_gen.sv
// nes_clk_enable_gen
// Clock-enable and reset sequencer for the NES core. Runs on the PLL master
// clock (clkoutd3) and produces:
//   - nes_rstn : core reset, released RST_HOLD_CYCLES after PLL lock is seen
//   - cpu_ce   : one-cycle pulse on the last master cycle of each CPU cycle
//   - ppu_ce   : one-cycle pulse on the last master cycle of each PPU dot
//   - phase    : master-cycle index inside the current CPU cycle
//   - pause_ack: core frozen on a CPU-cycle boundary at the OSD/loader's request
//
// Build option: define NES_PAL_TIMING_EN for PAL timing (16 master cycles per
// CPU cycle, 5 per PPU dot). PAL PPU timing does not divide the CPU cycle, so
// it runs from its own counter; NTSC derives ppu_ce from phase.
//
// Handshake: pause_req is a level. The core stops only at the edge where
// cpu_ce is high and pause_req is high; pause_ack is high for every frozen
// cycle. Dropping pause_req releases the core on the next clock, and phase
// restarts at 0 in that same cycle, so no partial CPU cycle is ever produced.
// Loss of PLL lock overrides everything, including an active pause.

module nes_clk_enable_gen #(
   parameter int RST_HOLD_CYCLES = 1024,
   parameter int CPU_DIV         = 12,
   parameter int PPU_DIV         = 4
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       pll_lock,
   input  logic       pause_req,
   output logic       pause_ack,
   output logic       nes_rstn,
   output logic       cpu_ce,
   output logic       ppu_ce,
   output logic [3:0] phase
);

`ifdef NES_PAL_TIMING_EN
   localparam int CPU_LEN = 16;
   localparam int PPU_LEN = 5;
`else
   localparam int CPU_LEN = CPU_DIV;
   localparam int PPU_LEN = PPU_DIV;
`endif

   localparam int               HOLD_W     = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
   localparam logic [3:0]        PHASE_LAST = 4'(CPU_LEN - 1);

   // Elaboration-time sanity checks on the divider configuration
   generate
      if (CPU_LEN > 16 || CPU_LEN < 2) begin : g_bad_cpu_div
         $error("nes_clk_enable_gen: CPU divider must be in 2..16 for a 4-bit phase");
      end
      if (RST_HOLD_CYCLES < 1) begin : g_bad_hold
         $error("nes_clk_enable_gen: RST_HOLD_CYCLES must be at least 1");
      end
`ifndef NES_PAL_TIMING_EN
      if (PPU_LEN < 1 || (CPU_LEN % PPU_LEN) != 0) begin : g_bad_ppu_div
         $error("nes_clk_enable_gen: PPU_DIV must divide CPU_DIV");
      end
`endif
   endgenerate

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      HOLD      = 2'd1,
      RUN       = 2'd2,
      PAUSED    = 2'd3
   } state_t;

   state_t            state;
   logic              lock_meta;
   logic              lock_s;
   logic [HOLD_W-1:0] hold_cnt;

   // Values phase and the enables take on the next RUN cycle
   logic [3:0] phase_nxt;
   logic       cpu_ce_nxt;
   logic       ppu_ce_nxt;

`ifdef NES_PAL_TIMING_EN
   localparam logic [2:0] PPU_LAST = 3'(PPU_LEN - 1);
   logic [2:0] ppu_cnt;
   logic [2:0] ppu_cnt_nxt;
`else
   logic [3:0] ppu_mod;
`endif

   // Next-cycle phase and enable decode; the enables are registered so they
   // line up with the registered phase they describe
   always_comb begin
      phase_nxt  = (phase == PHASE_LAST) ? 4'd0 : phase + 4'd1;
      cpu_ce_nxt = (phase_nxt == PHASE_LAST);
`ifdef NES_PAL_TIMING_EN
      ppu_cnt_nxt = (ppu_cnt == PPU_LAST) ? 3'd0 : ppu_cnt + 3'd1;
      ppu_ce_nxt  = (ppu_cnt_nxt == PPU_LAST);
`else
      ppu_mod    = phase_nxt % 4'(PPU_LEN);
      ppu_ce_nxt = (ppu_mod == 4'(PPU_LEN - 1));
`endif
   end

   // Two-flop synchroniser for the asynchronous PLL lock
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lock_meta <= 1'b0;
         lock_s    <= 1'b0;
      end else begin
         lock_meta <= pll_lock;
         lock_s    <= lock_meta;
      end
   end

   // Sequencer FSM with registered reset, enable, phase and pause outputs
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= WAIT_LOCK;
         hold_cnt  <= '0;
         phase     <= 4'd0;
         cpu_ce    <= 1'b0;
         ppu_ce    <= 1'b0;
         pause_ack <= 1'b0;
         nes_rstn  <= 1'b0;
`ifdef NES_PAL_TIMING_EN
         ppu_cnt   <= 3'd0;
`endif
      end else if (!lock_s) begin
         // Lock lost (or never gained): hold the core in reset from any state
         state     <= WAIT_LOCK;
         hold_cnt  <= '0;
         phase     <= 4'd0;
         cpu_ce    <= 1'b0;
         ppu_ce    <= 1'b0;
         pause_ack <= 1'b0;
         nes_rstn  <= 1'b0;
`ifdef NES_PAL_TIMING_EN
         ppu_cnt   <= 3'd0;
`endif
      end else begin
         case (state)
            WAIT_LOCK: begin
               state    <= HOLD;
               hold_cnt <= '0;
               nes_rstn <= 1'b0;
            end

            HOLD: begin
               if (hold_cnt == HOLD_LAST) begin
                  state    <= RUN;
                  hold_cnt <= '0;
                  nes_rstn <= 1'b1;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end

            RUN: begin
               if (cpu_ce && pause_req) begin
                  // CPU cycle just completed: freeze at the boundary
                  state     <= PAUSED;
                  phase     <= 4'd0;
                  cpu_ce    <= 1'b0;
                  ppu_ce    <= 1'b0;
                  pause_ack <= 1'b1;
`ifdef NES_PAL_TIMING_EN
                  ppu_cnt   <= 3'd0;
`endif
               end else begin
                  phase  <= phase_nxt;
                  cpu_ce <= cpu_ce_nxt;
                  ppu_ce <= ppu_ce_nxt;
`ifdef NES_PAL_TIMING_EN
                  ppu_cnt <= ppu_cnt_nxt;
`endif
               end
            end

            PAUSED: begin
               // Phase stays at 0; release restarts a full CPU cycle
               phase  <= 4'd0;
               cpu_ce <= 1'b0;
               ppu_ce <= 1'b0;
               if (!pause_req) begin
                  state     <= RUN;
                  pause_ack <= 1'b0;
               end
            end

            default: begin
               state    <= WAIT_LOCK;
               nes_rstn <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nes_clk_enable_gen.sv
// Directed testbench for nes_clk_enable_gen: lock-to-reset timing, enable
// cadence, pause handshake, lock loss in RUN and PAUSED, and async reset.
// Honours NES_PAL_TIMING_EN for the expected divider values.

module tb_nes_clk_enable_gen;

`ifdef NES_PAL_TIMING_EN
   localparam int CPU_N   = 16;
   localparam int PPU_N   = 5;
   localparam int WIN     = 80;
   localparam int WIN_CPU = 5;
   localparam int WIN_PPU = 16;
`else
   localparam int CPU_N   = 12;
   localparam int PPU_N   = 4;
   localparam int WIN     = 1200;
   localparam int WIN_CPU = 100;
   localparam int WIN_PPU = 300;
`endif
   localparam int RST_HOLD   = 1024;
   // 2 synchroniser clocks + 1 WAIT_LOCK->HOLD clock + RST_HOLD counted clocks
   localparam int HOLD_TOTAL = 2 + RST_HOLD + 1;

   logic       clk;
   logic       resetn;
   logic       pll_lock;
   logic       pause_req;
   logic       pause_ack;
   logic       nes_rstn;
   logic       cpu_ce;
   logic       ppu_ce;
   logic [3:0] phase;

   int n_checks = 0;
   int n_errors = 0;
   int k_run    = 0;
   int model_bad;
   int cnt_cpu;
   int cnt_ppu;

   nes_clk_enable_gen #(
      .RST_HOLD_CYCLES (RST_HOLD),
      .CPU_DIV         (12),
      .PPU_DIV         (4)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .pll_lock  (pll_lock),
      .pause_req (pause_req),
      .pause_ack (pause_ack),
      .nes_rstn  (nes_rstn),
      .cpu_ce    (cpu_ce),
      .ppu_ce    (ppu_ce),
      .phase     (phase)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   // Advance n rising edges, then settle 1 time unit past the edge
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Wait for the reset release after lock, checking that nothing leaks early
   task automatic wait_rise(input string tag);
      int pulses = 0;
      int early  = 0;
      for (int i = 1; i < HOLD_TOTAL; i++) begin
         tick(1);
         if (cpu_ce !== 1'b0 || ppu_ce !== 1'b0) pulses++;
         if (nes_rstn !== 1'b0) early++;
      end
      check({tag, "_early_rstn"}, early, 0);
      check({tag, "_early_ce"}, pulses, 0);
      tick(1);
      check({tag, "_rstn_rise"}, nes_rstn, 1);
      check({tag, "_phase0"}, phase, 0);
      check({tag, "_cpu_ce0"}, cpu_ce, 0);
   endtask

   // Run n cycles against an independent cycle-count model of the enables
   task automatic run_model(input int n);
      for (int i = 0; i < n; i++) begin
         tick(1);
         k_run++;
         if (phase !== 4'(k_run % CPU_N)) model_bad++;
         if (cpu_ce !== ((k_run % CPU_N) == CPU_N - 1)) model_bad++;
         if (ppu_ce !== ((k_run % PPU_N) == PPU_N - 1)) model_bad++;
         if (cpu_ce === 1'b1) cnt_cpu++;
         if (ppu_ce === 1'b1) cnt_ppu++;
      end
   endtask

   initial begin
      int pulses;
      int ack_low;

      // Reset state
      resetn    = 1'b0;
      pll_lock  = 1'b1;
      pause_req = 1'b0;
      #3;
      check("rst_nes_rstn", nes_rstn, 0);
      check("rst_phase", phase, 0);
      check("rst_cpu_ce", cpu_ce, 0);
      check("rst_ppu_ce", ppu_ce, 0);
      check("rst_pause_ack", pause_ack, 0);
      tick(2);
      check("rst_hold_rstn", nes_rstn, 0);

      // Lock already present at release: reset rises after the full sequence
      resetn = 1'b1;
      wait_rise("boot");

      // Enable cadence
      k_run = 0;
      tick(PPU_N - 1);
      k_run += PPU_N - 1;
      check("first_ppu_phase", phase, PPU_N - 1);
      check("first_ppu_ce", ppu_ce, 1);
      check("first_ppu_cpu_ce", cpu_ce, 0);
      tick(CPU_N - PPU_N);
      k_run += CPU_N - PPU_N;
      check("first_cpu_phase", phase, CPU_N - 1);
      check("first_cpu_ce", cpu_ce, 1);
      check("first_cpu_ppu_ce", ppu_ce, ((CPU_N - 1) % PPU_N) == PPU_N - 1);

      model_bad = 0;
      cnt_cpu   = 0;
      cnt_ppu   = 0;
      run_model(WIN);
      check("win_model", model_bad, 0);
      check("win_cpu_count", cnt_cpu, WIN_CPU);
      check("win_ppu_count", cnt_ppu, WIN_PPU);

      // Pause requested mid CPU cycle: completes the cycle, then freezes
      tick(5);
      check("pause_req_phase", phase, 4);
      pause_req = 1'b1;
      tick(CPU_N - 5);
      check("pause_boundary_cpu_ce", cpu_ce, 1);
      check("pause_boundary_ack", pause_ack, 0);
      tick(1);
      check("paused_ack", pause_ack, 1);
      check("paused_phase", phase, 0);
      check("paused_cpu_ce", cpu_ce, 0);
      check("paused_ppu_ce", ppu_ce, 0);
      pulses  = 0;
      ack_low = 0;
      for (int i = 0; i < 49; i++) begin
         tick(1);
         if (cpu_ce !== 1'b0 || ppu_ce !== 1'b0 || phase !== 4'd0) pulses++;
         if (pause_ack !== 1'b1) ack_low++;
      end
      check("paused_no_activity", pulses, 0);
      check("paused_ack_held", ack_low, 0);
      pause_req = 1'b0;
      tick(1);
      check("resume_ack", pause_ack, 0);
      check("resume_phase", phase, 0);
      tick(CPU_N - 2);
      check("resume_pre_phase", phase, CPU_N - 2);
      check("resume_pre_cpu_ce", cpu_ce, 0);
      tick(1);
      check("resume_cpu_ce", cpu_ce, 1);

      // Lock loss during RUN
      tick(2);
      check("run_loss_phase_start", phase, 1);
      pll_lock = 1'b0;
      tick(2);
      check("run_loss_still_rstn", nes_rstn, 1);
      check("run_loss_still_phase", phase, 3);
      tick(1);
      check("run_loss_rstn", nes_rstn, 0);
      check("run_loss_phase", phase, 0);
      check("run_loss_cpu_ce", cpu_ce, 0);

      // Relock with pause already requested during HOLD
      pause_req = 1'b1;
      pll_lock  = 1'b1;
      wait_rise("relock");
      check("relock_ack_idle", pause_ack, 0);
      tick(CPU_N - 1);
      check("relock_cpu_ce", cpu_ce, 1);
      check("relock_ack_pre", pause_ack, 0);
      tick(1);
      check("relock_paused_ack", pause_ack, 1);
      check("relock_paused_phase", phase, 0);
      tick(3);

      // Lock loss while PAUSED
      pll_lock = 1'b0;
      tick(2);
      check("pause_loss_ack_held", pause_ack, 1);
      check("pause_loss_rstn_held", nes_rstn, 1);
      tick(1);
      check("pause_loss_ack", pause_ack, 0);
      check("pause_loss_rstn", nes_rstn, 0);
      check("pause_loss_phase", phase, 0);

      // Async reset mid-HOLD restarts the whole sequence
      pause_req = 1'b0;
      pll_lock  = 1'b1;
      tick(500);
      check("mid_hold_rstn", nes_rstn, 0);
      resetn = 1'b0;
      #2;
      check("mid_hold_rst_rstn", nes_rstn, 0);
      check("mid_hold_rst_ack", pause_ack, 0);
      resetn = 1'b1;
      wait_rise("after_reset");

      // Async reset in RUN clears outputs without a clock edge
      tick(5);
      check("pre_async_phase", phase, 5);
      resetn = 1'b0;
      #2;
      check("async_phase", phase, 0);
      check("async_rstn", nes_rstn, 0);
      check("async_cpu_ce", cpu_ce, 0);
      check("async_ppu_ce", ppu_ce, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
